// File: rtl/tetris_pkg.sv
// Shared types and tables for the active-piece controller: FSM states,
// tetromino cell offsets per rotation, and spawn placement helpers.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_FALL  = 3'd2,
        ST_LOCK  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Types: 0 I, 1 J, 2 L, 3 O, 4 S, 5 T, 6 Z. dy counts downward from the anchor row.
    localparam logic [1:0] PIECE_DX [7][4][4] = '{
        '{'{0,1,2,3}, '{2,2,2,2}, '{0,1,2,3}, '{1,1,1,1}},
        '{'{0,0,1,2}, '{1,2,1,1}, '{0,1,2,2}, '{1,1,0,1}},
        '{'{2,0,1,2}, '{1,1,1,2}, '{0,1,2,0}, '{0,1,1,1}},
        '{'{1,2,1,2}, '{1,2,1,2}, '{1,2,1,2}, '{1,2,1,2}},
        '{'{1,2,0,1}, '{1,1,2,2}, '{1,2,0,1}, '{0,0,1,1}},
        '{'{1,0,1,2}, '{1,1,2,1}, '{0,1,2,1}, '{1,0,1,1}},
        '{'{0,1,1,2}, '{2,1,2,1}, '{0,1,1,2}, '{1,0,1,0}}
    };

    localparam logic [1:0] PIECE_DY [7][4][4] = '{
        '{'{1,1,1,1}, '{0,1,2,3}, '{2,2,2,2}, '{0,1,2,3}},
        '{'{0,1,1,1}, '{0,0,1,2}, '{1,1,1,2}, '{0,1,2,2}},
        '{'{0,1,1,1}, '{0,1,2,2}, '{1,1,1,2}, '{0,0,1,2}},
        '{'{0,0,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,0,1,1}},
        '{'{0,0,1,1}, '{0,1,1,2}, '{1,1,2,2}, '{0,1,1,2}},
        '{'{0,1,1,1}, '{0,1,1,2}, '{1,1,1,2}, '{0,1,1,2}},
        '{'{0,0,1,1}, '{0,1,1,2}, '{1,1,2,2}, '{0,1,1,2}}
    };

    localparam logic [1:0] SPAWN_ROT = 2'd0;

    function automatic int spawn_col(input int width);
        return (width - 4) / 2;
    endfunction

    function automatic int spawn_row(input int height);
        return height - 1;
    endfunction

endpackage

// File: rtl/piece_fits.sv
// Combinational placement check: expands an anchor/type/rotation into four
// cells and reports whether all of them are on the board and unoccupied.
module piece_fits
    import tetris_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int XSIZE  = 3,
    parameter int YSIZE  = 3
) (
    input  logic signed [XSIZE+1:0]       ax,
    input  logic signed [YSIZE:0]         ay,
    input  logic [2:0]                    ptype,
    input  logic [1:0]                    rot,
    input  logic [HEIGHT-1:0][WIDTH-1:0]  lockedMatrix,
    output logic                          legal,
    output logic [3:0][XSIZE-1:0]         cellX,
    output logic [3:0][YSIZE-1:0]         cellY
);

    localparam logic signed [XSIZE+2:0] XLIM = (XSIZE+3)'(WIDTH);
    localparam logic signed [YSIZE+1:0] YLIM = (YSIZE+2)'(HEIGHT);

    logic signed [XSIZE+2:0] cx [4];
    logic signed [YSIZE+1:0] cy [4];

    always_comb begin
        legal = 1'b1;
        cellX = '0;
        cellY = '0;
        for (int k = 0; k < 4; k++) begin
            cx[k] = {ax[XSIZE+1], ax} + (XSIZE+3)'(PIECE_DX[ptype][rot][k]);
            cy[k] = {ay[YSIZE], ay} - (YSIZE+2)'(PIECE_DY[ptype][rot][k]);
            cellX[k] = cx[k][XSIZE-1:0];
            cellY[k] = cy[k][YSIZE-1:0];
            // Bounds are checked first; the matrix lookup only matters once in range.
            if (cx[k][XSIZE+2] || (cx[k] >= XLIM) || cy[k][YSIZE+1] || (cy[k] >= YLIM)
                || lockedMatrix[cellY[k]][cellX[k]])
                legal = 1'b0;
        end
    end

endmodule

// File: rtl/piece_mover.sv
// Active-piece controller: spawns, moves and rotates a tetromino against the
// locked matrix and hands it to the locker with a one-cycle fix pulse.
//
// state | meaning
// WAIT  | no piece; waiting for the locker to report fixdone
// SPAWN | load next piece at the top, check it fits
// FALL  | piece active; apply one gravity/move/rotate request per cycle
// LOCK  | present final cells with fix=1 for one cycle
// OVER  | spawn collided; gameOver held until reset
module piece_mover
    import tetris_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int XSIZE  = 3,
    parameter int YSIZE  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [HEIGHT-1:0][WIDTH-1:0]  lockedMatrix,
    input  logic                          fixdone,
    input  logic [2:0]                    pieceType,
    input  logic                          dropTick,
    input  logic                          left,
    input  logic                          right,
    input  logic                          rotate,
    output logic [3:0][XSIZE-1:0]         outX,
    output logic [3:0][YSIZE-1:0]         outY,
    output logic                          fix,
    output logic                          active,
    output logic                          gameOver
);

    localparam logic signed [XSIZE+1:0] SPAWN_AX = (XSIZE+2)'(spawn_col(WIDTH));
    localparam logic signed [YSIZE:0]   SPAWN_AY = (YSIZE+1)'(spawn_row(HEIGHT));
    localparam logic signed [XSIZE+1:0] ONE_X    = (XSIZE+2)'(1);
    localparam logic signed [YSIZE:0]   ONE_Y    = (YSIZE+1)'(1);

    state_t                  state, state_nx;
    logic signed [XSIZE+1:0] ax, cand_ax;
    logic signed [YSIZE:0]   ay, cand_ay;
    logic [1:0]              rot, cand_rot;
    logic [2:0]              ptype, cand_type;
    logic                    cand_legal, cur_legal, commit;
    logic [3:0][XSIZE-1:0]   cur_x;
    logic [3:0][YSIZE-1:0]   cur_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WAIT;
            ax    <= '0;
            ay    <= '0;
            rot   <= '0;
            ptype <= '0;
        end else begin
            state <= state_nx;
            if (commit) begin
                ax    <= cand_ax;
                ay    <= cand_ay;
                rot   <= cand_rot;
                ptype <= cand_type;
            end
        end
    end

    // Candidate mux: spawn placement or the single winning FALL request.
    always_comb begin
        cand_ax   = ax;
        cand_ay   = ay;
        cand_rot  = rot;
        cand_type = ptype;
        if (state == ST_SPAWN) begin
            cand_type = (pieceType == 3'd7) ? 3'd0 : pieceType;
            cand_rot  = SPAWN_ROT;
            cand_ax   = SPAWN_AX;
            cand_ay   = SPAWN_AY;
        end else if (state == ST_FALL) begin
            if (dropTick)    cand_ay  = ay - ONE_Y;
            else if (rotate) cand_rot = rot + 2'd1;
            else if (left)   cand_ax  = ax - ONE_X;
            else if (right)  cand_ax  = ax + ONE_X;
        end
    end

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            ST_WAIT:  if (fixdone) state_nx = ST_SPAWN;
            ST_SPAWN: begin
                commit   = 1'b1;
                state_nx = cand_legal ? ST_FALL : ST_OVER;
            end
            ST_FALL: begin
                if (dropTick) begin
                    commit = cand_legal;
                    if (!cand_legal) state_nx = ST_LOCK;
                end else if (rotate || left || right) begin
                    commit = cand_legal;
                end
            end
            ST_LOCK:  state_nx = ST_WAIT;
            ST_OVER:  state_nx = ST_OVER;
            default:  state_nx = ST_WAIT;
        endcase
    end

    piece_fits #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XSIZE(XSIZE), .YSIZE(YSIZE)) u_cand_fits (
        .ax(cand_ax), .ay(cand_ay), .ptype(cand_type), .rot(cand_rot),
        .lockedMatrix(lockedMatrix), .legal(cand_legal), .cellX(), .cellY()
    );

    piece_fits #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XSIZE(XSIZE), .YSIZE(YSIZE)) u_cur_fits (
        .ax(ax), .ay(ay), .ptype(ptype), .rot(rot),
        .lockedMatrix(lockedMatrix), .legal(cur_legal), .cellX(cur_x), .cellY(cur_y)
    );

    assign active   = (state == ST_FALL) || (state == ST_LOCK);
    assign fix      = (state == ST_LOCK);
    assign gameOver = (state == ST_OVER);
    assign outX     = active ? cur_x : '0;
    assign outY     = active ? cur_y : '0;

    // Only committed positions are ever shown, so the on-screen piece must fit.
    always_ff @(posedge clk) begin
        if (!reset && active)
            assert (cur_legal) else $error("active piece overlaps or leaves the board");
    end

endmodule

// File: tb/tb_piece_mover.sv
// Directed bench for piece_mover: spawn, gravity, moves, rotation, lock and game over.
module tb_piece_mover;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0][7:0]  lockedMatrix;
    logic             fixdone;
    logic [2:0]       pieceType;
    logic             dropTick, left, right, rotate;
    logic [3:0][2:0]  outX, outY;
    logic             fix, active, gameOver;

    int checks = 0;
    int errors = 0;

    piece_mover #(.WIDTH(8), .HEIGHT(8), .XSIZE(3), .YSIZE(3)) dut (
        .clk(clk), .reset(reset), .lockedMatrix(lockedMatrix), .fixdone(fixdone),
        .pieceType(pieceType), .dropTick(dropTick), .left(left), .right(right),
        .rotate(rotate), .outX(outX), .outY(outY), .fix(fix), .active(active),
        .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_drop();  dropTick = 1'b1; tick(); dropTick = 1'b0; tick(); endtask
    task automatic pulse_left();  left     = 1'b1; tick(); left     = 1'b0; tick(); endtask
    task automatic pulse_right(); right    = 1'b1; tick(); right    = 1'b0; tick(); endtask
    task automatic pulse_rot();   rotate   = 1'b1; tick(); rotate   = 1'b0; tick(); endtask

    initial begin
        reset = 1'b1; lockedMatrix = '0; fixdone = 1'b0; pieceType = 3'd0;
        dropTick = 1'b0; left = 1'b0; right = 1'b0; rotate = 1'b0;
        tick(); tick();
        chk("rst_active", active, 0);
        chk("rst_fix", fix, 0);
        chk("rst_over", gameOver, 0);
        chk("rst_outx", outX, 0);
        chk("rst_outy", outY, 0);

        // O spawn on empty matrix
        reset = 1'b0; pieceType = 3'd3; fixdone = 1'b1;
        tick();
        chk("spawn_cycle_active", active, 0);
        fixdone = 1'b0;
        tick();
        chk("o_spawn_active", active, 1);
        chk("o_spawn_fix", fix, 0);
        chk("o_spawn_x", outX, {3'd4, 3'd3, 3'd4, 3'd3});
        chk("o_spawn_y", outY, {3'd6, 3'd6, 3'd7, 3'd7});

        // six drops to the floor, seventh locks
        repeat (6) pulse_drop();
        chk("o_floor_y", outY, {3'd0, 3'd0, 3'd1, 3'd1});
        chk("o_floor_x", outX, {3'd4, 3'd3, 3'd4, 3'd3});
        dropTick = 1'b1; tick(); dropTick = 1'b0;
        chk("o_lock_fix", fix, 1);
        chk("o_lock_active", active, 1);
        chk("o_lock_y", outY, {3'd0, 3'd0, 3'd1, 3'd1});
        chk("o_lock_x", outX, {3'd4, 3'd3, 3'd4, 3'd3});
        tick();
        chk("o_wait_fix", fix, 0);
        chk("o_wait_active", active, 0);
        tick(); tick();
        chk("o_wait_hold", active, 0);

        // respawn once the locker is ready again
        fixdone = 1'b1; tick(); fixdone = 1'b0; tick();
        chk("o_respawn_active", active, 1);
        chk("o_respawn_y", outY, {3'd6, 3'd6, 3'd7, 3'd7});

        // left to the wall, fourth left rejected
        pulse_left();
        chk("left1_x", outX, {3'd3, 3'd2, 3'd3, 3'd2});
        pulse_left();
        chk("left2_x", outX, {3'd2, 3'd1, 3'd2, 3'd1});
        pulse_left();
        chk("left3_x", outX, {3'd1, 3'd0, 3'd1, 3'd0});
        pulse_left();
        chk("left4_x", outX, {3'd1, 3'd0, 3'd1, 3'd0});
        chk("left4_y", outY, {3'd6, 3'd6, 3'd7, 3'd7});

        // drop beats left in the same cycle
        dropTick = 1'b1; left = 1'b1; tick(); dropTick = 1'b0; left = 1'b0;
        chk("prio_y", outY, {3'd5, 3'd5, 3'd6, 3'd6});
        chk("prio_x", outX, {3'd1, 3'd0, 3'd1, 3'd0});
        right = 1'b1; tick(); right = 1'b0;
        chk("right_x", outX, {3'd2, 3'd1, 3'd2, 3'd1});

        // reset mid-piece
        reset = 1'b1; tick();
        chk("midrst_active", active, 0);
        chk("midrst_fix", fix, 0);
        reset = 1'b0;

        // I piece: rotate, push right to the wall, blocked rotate, then lock on a cell
        pieceType = 3'd0; fixdone = 1'b1; tick(); fixdone = 1'b0; tick();
        chk("i_spawn_x", outX, {3'd5, 3'd4, 3'd3, 3'd2});
        chk("i_spawn_y", outY, {3'd6, 3'd6, 3'd6, 3'd6});
        pulse_rot();
        chk("i_rot1_x", outX, {3'd4, 3'd4, 3'd4, 3'd4});
        chk("i_rot1_y", outY, {3'd4, 3'd5, 3'd6, 3'd7});
        repeat (3) pulse_right();
        chk("i_right_x", outX, {3'd7, 3'd7, 3'd7, 3'd7});
        pulse_right();
        chk("i_right_wall_x", outX, {3'd7, 3'd7, 3'd7, 3'd7});
        pulse_rot();
        chk("i_rot_block_x", outX, {3'd7, 3'd7, 3'd7, 3'd7});
        chk("i_rot_block_y", outY, {3'd4, 3'd5, 3'd6, 3'd7});
        lockedMatrix[3][7] = 1'b1;
        dropTick = 1'b1; tick(); dropTick = 1'b0;
        chk("i_lock_fix", fix, 1);
        chk("i_lock_y", outY, {3'd4, 3'd5, 3'd6, 3'd7});
        tick();
        chk("i_lock_done", fix, 0);

        // type 7 spawns as I
        lockedMatrix = '0; pieceType = 3'd7; fixdone = 1'b1; tick(); fixdone = 1'b0; tick();
        chk("t7_x", outX, {3'd5, 3'd4, 3'd3, 3'd2});
        chk("t7_y", outY, {3'd6, 3'd6, 3'd6, 3'd6});

        // spawn collision -> game over
        reset = 1'b1; tick(); reset = 1'b0;
        lockedMatrix[7][3] = 1'b1; pieceType = 3'd3; fixdone = 1'b1;
        tick();
        chk("go_spawn_fix", fix, 0);
        tick();
        chk("go_over", gameOver, 1);
        chk("go_active", active, 0);
        chk("go_fix", fix, 0);
        chk("go_outx", outX, 0);
        dropTick = 1'b1; left = 1'b1; rotate = 1'b1; tick(); tick();
        dropTick = 1'b0; left = 1'b0; rotate = 1'b0;
        chk("go_hold", gameOver, 1);
        chk("go_hold_fix", fix, 0);
        reset = 1'b1; tick();
        chk("go_cleared", gameOver, 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
